// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART-to-EBI host frame engine.
// Holds protocol defaults, FSM states, error codes and the CRC-8 helper.
package uart_frame_pkg;

    localparam logic [7:0] DEF_CRC_INIT = 8'h14;
    localparam logic [7:0] DEF_WR_HDR   = 8'hAB;
    localparam logic [7:0] DEF_RD_HDR   = 8'hAA;
    localparam logic [7:0] DEF_RSP_HDR  = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_HDR,
        ST_TX_AH,
        ST_TX_AL,
        ST_TX_DH,
        ST_TX_DL,
        ST_TX_CRC,
        ST_RX,
        ST_RSP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_HDR     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // CRC-8, poly x^8+x^2+x+1, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_07(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_frame_master.sv
// Host-side frame engine: turns read/write commands into CRC-8 framed bytes
// for a uart TX stream and parses/checks 4-byte read responses from uart RX.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata   local command port
//   rsp_valid/rdata/error         one-cycle completion with status
//   m_axis_*                      byte stream to uart TX
//   s_axis_*                      byte stream from uart RX (never stalled)
//   busy                          engine not idle
module uart_frame_master
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  CRC_INIT = DEF_CRC_INIT,
    parameter logic [7:0]  WR_HDR   = DEF_WR_HDR,
    parameter logic [7:0]  RD_HDR   = DEF_RD_HDR,
    parameter logic [7:0]  RSP_HDR  = DEF_RSP_HDR,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rsp_error,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [7:0]    crc;
    logic          wr_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [1:0]    rx_idx;
    logic          hdr_bad;
    logic [15:0]   rx_data;
    logic [CW-1:0] to_cnt;

    logic          tx_fire;
    logic [7:0]    crc_tx_nxt;
    logic [7:0]    crc_rx_nxt;

    assign tx_fire    = m_axis_tvalid & m_axis_tready;
    assign crc_tx_nxt = crc8_07(crc, m_axis_tdata);
    assign crc_rx_nxt = crc8_07(crc, s_axis_tdata);

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign s_axis_tready = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            crc           <= CRC_INIT;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rx_idx        <= '0;
            hdr_bad       <= 1'b0;
            rx_data       <= '0;
            to_cnt        <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_error     <= ERR_OK;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    crc <= CRC_INIT;
                    if (cmd_valid) begin
                        wr_q          <= cmd_write;
                        addr_q        <= cmd_addr;
                        wdata_q       <= cmd_wdata;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= cmd_write ? WR_HDR : RD_HDR;
                        state         <= ST_TX_HDR;
                    end
                end
                ST_TX_HDR: if (tx_fire) begin
                    crc          <= crc_tx_nxt;
                    m_axis_tdata <= addr_q[15:8];
                    state        <= ST_TX_AH;
                end
                ST_TX_AH: if (tx_fire) begin
                    crc          <= crc_tx_nxt;
                    m_axis_tdata <= addr_q[7:0];
                    state        <= ST_TX_AL;
                end
                ST_TX_AL: if (tx_fire) begin
                    crc <= crc_tx_nxt;
                    if (wr_q) begin
                        m_axis_tdata <= wdata_q[15:8];
                        state        <= ST_TX_DH;
                    end else begin
                        m_axis_tdata <= crc_tx_nxt;
                        state        <= ST_TX_CRC;
                    end
                end
                ST_TX_DH: if (tx_fire) begin
                    crc          <= crc_tx_nxt;
                    m_axis_tdata <= wdata_q[7:0];
                    state        <= ST_TX_DL;
                end
                ST_TX_DL: if (tx_fire) begin
                    crc          <= crc_tx_nxt;
                    m_axis_tdata <= crc_tx_nxt;
                    state        <= ST_TX_CRC;
                end
                ST_TX_CRC: if (tx_fire) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tdata  <= '0;
                    crc           <= CRC_INIT;
                    to_cnt        <= '0;
                    rx_idx        <= '0;
                    hdr_bad       <= 1'b0;
                    if (wr_q) begin
                        // Writes are posted: complete as soon as the frame is out.
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_error <= ERR_OK;
                        state     <= ST_RSP;
                    end else begin
                        state <= ST_RX;
                    end
                end
                ST_RX: begin
                    if (s_axis_tvalid) begin
                        // A byte beats a same-cycle timeout.
                        to_cnt <= '0;
                        crc    <= crc_rx_nxt;
                        rx_idx <= rx_idx + 2'd1;
                        unique case (rx_idx)
                            2'd0: hdr_bad <= (s_axis_tdata != RSP_HDR);
                            2'd1: rx_data[15:8] <= s_axis_tdata;
                            2'd2: rx_data[7:0]  <= s_axis_tdata;
                            2'd3: begin
                                rsp_valid <= 1'b1;
                                state     <= ST_RSP;
                                if (hdr_bad) begin
                                    rsp_error <= ERR_HDR;
                                    rsp_rdata <= '0;
                                end else if (s_axis_tdata != crc) begin
                                    rsp_error <= ERR_CRC;
                                    rsp_rdata <= '0;
                                end else begin
                                    rsp_error <= ERR_OK;
                                    rsp_rdata <= rx_data;
                                end
                            end
                            default: ;
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= ERR_TIMEOUT;
                        rsp_rdata <= '0;
                        state     <= ST_RSP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RSP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_frame_master.md
Name: uart_frame_master

Overview:
- Host-side frame engine for the UART-to-EBI bridge protocol. It sits between a local command port and the byte-wide AXI-stream interface of a `uart` core; the far end of that UART link is the bridge.
- Serialises read/write commands into CRC-protected frames, then parses and checks read-response frames.
- Lets an FPGA-resident controller drive a remote bridge's EBI space with no CPU in the loop.

Parameters:
- CRC_INIT, 8'h14, initial CRC-8 value for every frame, TX and RX.
- WR_HDR, 8'hAB, header byte of a write frame.
- RD_HDR, 8'hAA, header byte of a read frame.
- RSP_HDR, 8'hAA, required first byte of a read-response frame.
- TIMEOUT, 1000000, maximum idle clk cycles between response bytes (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  16  EBI address
- cmd_wdata  in  16  write data (ignored on read)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data (0 for writes and on error)
- rsp_error  out  2  0 OK, 1 CRC mismatch, 2 bad header, 3 timeout
- m_axis_tdata  out  8  byte to uart TX (uart s_axis)
- m_axis_tvalid  out  1  TX byte valid
- m_axis_tready  in  1  uart TX ready
- s_axis_tdata  in  8  byte from uart RX (uart m_axis)
- s_axis_tvalid  in  1  RX byte valid
- s_axis_tready  out  1  constant 1; the block never back-pressures RX
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, state IDLE, CRC=CRC_INIT, timeout counter=0.
- CRC: CRC-8, polynomial 0x07 (x^8+x^2+x+1), byte-parallel, no reflection, no final XOR.
  - Running value is updated with each byte as that byte is sent or received.
- cmd_ready equals (state==IDLE). Fields are registered on the cycle of a cmd_valid&&cmd_ready handshake.
- The first byte is on m_axis at the next cycle.
- Write frame: WR_HDR, addr[15:8], addr[7:0], wdata[15:8], wdata[7:0], CRC.
- Read frame: RD_HDR, addr[15:8], addr[7:0], CRC.
- TX handshake: a byte transfers on m_axis_tvalid&&m_axis_tready.
  - tdata is stable while tvalid is high and unaccepted.
  - The next byte is presented in the cycle after the transfer; tvalid does not drop between bytes of a frame.
- States: IDLE → TX_HDR → TX_AH → TX_AL → (write: TX_DH → TX_DL) → TX_CRC.
  - After TX_CRC, a write goes to RSP; a read goes to RX.
  - RX → RSP → IDLE.
- Writes are posted: once the CRC byte is accepted, RSP pulses rsp_valid with rsp_error=0.
- RX expects 4 bytes: RSP_HDR, data[15:8], data[7:0], CRC over the first three bytes.
  - Byte index counts 0..3.
  - At byte 3, a CRC mismatch gives error 1.
  - A byte 0 that differs from RSP_HDR gives error 2. All 4 bytes are still consumed before reporting, and header error takes priority over CRC error.
- Timeout: the counter clears on entry to RX and on every RX byte.
  - Reaching TIMEOUT-1 with no byte: go to RSP with error 3. Received bytes are discarded.
- rsp_valid is exactly 1 cycle. rsp_rdata/rsp_error hold their values until the next rsp_valid.
- The cycle after RSP, the block is in IDLE and cmd_ready=1.
- RX bytes arriving outside the RX state are dropped silently and do not disturb the CRC.
- An RX byte and a timeout in the same cycle: the byte wins and the counter clears.
- rst in any state: immediate return to reset values. A partially sent frame is abandoned and tvalid is deasserted next cycle.

Decomposition:
- Package uart_frame_pkg holds:
  - the default CRC_INIT, WR_HDR, RD_HDR and RSP_HDR values;
  - a state enum localparam set;
  - error-code localparams;
  - a crc8_07 function (crc, byte → crc).
- The bench reuses this package for its model.
- No sub-module: the CRC is a function call. An implementation is ~200 lines.

Test Plan:
- Write addr 0x1234, data 0x5678 with tready=1 → m_axis bytes AB 12 34 56 78, then the CRC (bench model, init 0x14); rsp_valid 1 cycle after the last byte; error 0.
- Read addr 0x0010; responder returns AA AB AB crc → bytes AA 00 10 crc sent; rsp_rdata=0xABAB, error 0.
- Loopback to a real uart2ebi through two uart cores at prescale 13, ebi_din=0xABAB:
  - sequence write 0x0001/0xFFEE, read 0x0011, read 0x0012;
  - expected: bridge ebi_wren with addr 0x0001 and data 0xFFEE, both reads return 0xABAB.
- Response with a corrupted CRC byte → error 1, rdata 0. Response with header 0x55 and a bad CRC → error 2.
- Read with no response, TIMEOUT=100 → error 3 exactly 100 cycles after TX_CRC is accepted; cmd_ready high the next cycle.
- Random tready stalls on a write, plus rst asserted after byte 3:
  - tdata is stable during stalls;
  - after rst, tvalid=0 and cmd_ready=1 next cycle;
  - a following read completes normally.
